inst_fetch_unit: RTL and testbench
==================================

# inst_fetch_unit

Parametrised instruction-fetch front end that replaces hand-driven instruction stimulus into `processor`. It holds a loadable program memory and steps a PC through it each clock. It presents one instruction word per cycle with a valid flag, and supports stall, redirect (branch/jump) and halt-opcode detection, so programs run autonomously in both simulation and synthesis.

## Interface
- `DATA_W`, default 32: instruction word width.
- `DEPTH`, default 64: program memory depth in words; power of two, at least 2.
- `RESET_PC`, default 0: word address fetched first after `start`.
- `AW` (localparam) = $clog2(DEPTH).

- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `load_en`, input, 1: write `load_data` into memory at `load_addr`. Honoured only in IDLE/HALT.
- `load_addr`, input, AW: program write address.
- `load_data`, input, DATA_W: program write data.
- `start`, input, 1: begin fetching at `RESET_PC`. Honoured only in IDLE/HALT.
- `stall`, input, 1: consumer cannot accept; hold all outputs.
- `redirect_valid`, input, 1: replace PC with `redirect_pc`.
- `redirect_pc`, input, AW: redirect target (word address).
- `inst_out`, output, DATA_W: current instruction (drives `processor` Inst).
- `inst_valid`, output, 1: `inst_out` is a real instruction.
- `pc_out`, output, AW: word address of `inst_out`.
- `halted`, output, 1: HALT state.

## Operation
- States: IDLE, RUN, HALT.
  - IDLE → RUN on `start`.
  - RUN → HALT when a halt word is fetched.
  - HALT → RUN on `start`.
  - No other transitions. Reset always forces IDLE.
- Halt word: bits [DATA_W-1:DATA_W-6] == 6'h3F.
- RUN, no stall, no redirect:
  - `inst_out` ← mem[pc]; `pc_out` ← pc; pc ← pc+1 modulo DEPTH (wraps DEPTH-1 → 0); `inst_valid` ← 1.
- RUN, stall=1: pc, `inst_out`, `pc_out` and `inst_valid` all hold.
- Redirect has priority over stall:
  - pc ← `redirect_pc`; `inst_valid` ← 0 for one cycle (bubble).
  - Fetch from the target starts on the next cycle.
- Halt word fetched:
  - It is presented with `inst_valid`=1 for one cycle.
  - The state then becomes HALT; `inst_valid` ← 0 and `halted` ← 1.
  - A stall on the halt cycle holds it presented until the stall releases.
- `load_en` and `start` are ignored in RUN.
- `load_en` together with `start` in IDLE: the write completes, and fetch begins next cycle.
- Memory contents are not cleared by reset. Unloaded words read as whatever the RAM holds (X in simulation).

## Timing
- Reset values: `inst_out`=0, `inst_valid`=0, `pc_out`=0, `halted`=0; state IDLE; pc=`RESET_PC`.
- Start-to-first-valid latency:
  - `start` sampled at edge N.
  - The first fetch happens at N+1, so `inst_out` = mem[RESET_PC] valid after edge N+1.
- Throughput: one instruction per unstalled cycle.
- Redirect at edge N:
  - Bubble (`inst_valid`=0) after N.
  - Target instruction valid after N+1.
- Stall is sampled at each edge. Release takes effect the same edge it is seen low.
- `rst_n` low mid-run clears all outputs asynchronously. The next instruction requires a fresh `start`.

## Configuration
- Macro: `INST_FETCH_UNIT_PERF_EN`.
- With the macro defined:
  - Adds output `fetch_count` (32 bits).
  - Counts cycles with `inst_valid`=1 and stall=0 (instructions consumed).
  - Saturates at 32'hFFFF_FFFF; reset to 0; cleared on `start`.
- Without the macro: the port and counter are absent. Behaviour is otherwise identical.

## Structure
- Shared package `inst_fetch_pkg`:
  - state enum (IDLE/RUN/HALT)
  - `HALT_OPCODE` = 6'h3F
  - opcode field width 6
- Sub-module `inst_mem`: single-port RAM with DATA_W × DEPTH, sync write, registered sync read. Reads and writes never overlap.
- Top: FSM, PC register, redirect/stall muxing, optional counter.

## Test plan
- Load 32'h04430820, 32'h0C432022, 32'hFC000000 at 0..2, then pulse `start` → the add, then the sub, each valid one cycle after the previous; the halt word is valid at pc 2, then `halted`=1 and `inst_valid`=0.
- Run program, assert `stall` for 3 cycles on the sub → `inst_out`=32'h0C432022 and `pc_out`=1 held for 3 cycles, then resumes; with PERF_EN, `fetch_count`=3 at halt.
- `redirect_valid` with `redirect_pc`=5 while stalled at pc 1 → one bubble cycle, then mem[5] valid with `pc_out`=5.
- DEPTH=4, no halt word → `pc_out` sequence 0,1,2,3,0,1 (wrap).
- `rst_n` low mid-run → all outputs 0 immediately; `load_en`/`start` pulses during RUN leave memory and PC unchanged.
- `start` from HALT → restart at `RESET_PC` with `halted` low after the first edge.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Used by inst_fetch_unit and its inst_mem sub-module.
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHalt
  } fetch_state_e;

  localparam int unsigned OPCODE_W = 6;
  localparam logic [OPCODE_W-1:0] HALT_OPCODE = 6'h3F;

  function automatic logic is_halt_opcode(input logic [OPCODE_W-1:0] opcode);
    return opcode == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/inst_mem.sv
// Single-port program RAM: synchronous write, registered synchronous read.
// Only the read register is reset; the array itself keeps its contents.
module inst_mem #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register holds its value whenever re is low, which implements stall hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch front end: loadable program memory, PC sequencing, stall/redirect, halt detect.
// Optional INST_FETCH_UNIT_PERF_EN adds a saturating consumed-instruction counter (fetch_count).
module inst_fetch_unit
  import inst_fetch_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned RESET_PC = 0,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [AW-1:0]     load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              start,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [AW-1:0]     redirect_pc,
  output logic [DATA_W-1:0] inst_out,
  output logic              inst_valid,
  output logic [AW-1:0]     pc_out,
  output logic              halted
`ifdef INST_FETCH_UNIT_PERF_EN
  ,
  output logic [31:0]       fetch_count
`endif
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end
  if (RESET_PC >= DEPTH) begin : g_bad_reset_pc
    $error("RESET_PC must address a word inside the program memory");
  end
  if (DATA_W < OPCODE_W) begin : g_bad_width
    $error("DATA_W must hold the opcode field");
  end

  fetch_state_e      state_q, state_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [AW-1:0]     pc_out_q, pc_out_d;
  logic              valid_q, valid_d;
  logic              mem_we, mem_re;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              halt_presented;

  inst_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_inst_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (load_data),
    .rdata (mem_rdata)
  );

  assign halt_presented = valid_q && is_halt_opcode(mem_rdata[DATA_W-1 -: OPCODE_W]);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    mem_addr = pc_q;
    case (state_q)
      StIdle, StHalt: begin
        // A write and a start on the same edge both take effect; the fetch follows next edge.
        if (load_en) begin
          mem_we   = 1'b1;
          mem_addr = load_addr;
        end
        if (start) begin
          state_d = StRun;
          pc_d    = AW'(RESET_PC);
          valid_d = 1'b0;
        end
      end
      StRun: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
        end else if (!stall) begin
          if (halt_presented) begin
            // Halt word has been consumed; stop without fetching further.
            state_d = StHalt;
            valid_d = 1'b0;
          end else begin
            mem_re   = 1'b1;
            pc_out_d = pc_q;
            pc_d     = pc_q + AW'(1);
            valid_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      pc_q     <= AW'(RESET_PC);
      pc_out_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
    end
  end

  assign inst_out   = mem_rdata;
  assign inst_valid = valid_q;
  assign pc_out     = pc_out_q;
  assign halted     = (state_q == StHalt);

`ifdef INST_FETCH_UNIT_PERF_EN
  logic [31:0] fetch_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q <= '0;
    end else if (start && state_q != StRun) begin
      fetch_count_q <= '0;
    end else if (valid_q && !stall && fetch_count_q != 32'hFFFF_FFFF) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

  halted_no_valid: assert property (@(posedge clk) disable iff (!rst_n) halted |-> !inst_valid);
  valid_only_run: assert property (@(posedge clk) disable iff (!rst_n)
                                   inst_valid |-> state_q == StRun);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed vector table, wrap and reset sequences,
// and randomized traffic against a behavioural model of the fetch rules.
module tb_inst_fetch_unit;

  localparam int Depth = 64;
  localparam logic [31:0] InstAdd  = 32'h04430820;
  localparam logic [31:0] InstSub  = 32'h0C432022;
  localparam logic [31:0] InstHalt = 32'hFC000000;
  localparam logic [31:0] Inst5    = 32'h20A50005;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_en, start, stall, redirect_valid;
  logic [5:0]  load_addr, redirect_pc;
  logic [31:0] load_data;
  logic [31:0] inst_out;
  logic        inst_valid, halted;
  logic [5:0]  pc_out;

  logic        w_load_en, w_start;
  logic [1:0]  w_load_addr, w_pc_out;
  logic [31:0] w_load_data, w_inst_out;
  logic        w_inst_valid, w_halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef INST_FETCH_UNIT_PERF_EN
  logic [31:0] fetch_count, w_fetch_count;
`endif

  inst_fetch_unit #(.DATA_W(32), .DEPTH(Depth), .RESET_PC(0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_en        (load_en),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .start          (start),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_out       (inst_out),
    .inst_valid     (inst_valid),
    .pc_out         (pc_out),
    .halted         (halted)
`ifdef INST_FETCH_UNIT_PERF_EN
    ,
    .fetch_count    (fetch_count)
`endif
  );

  inst_fetch_unit #(.DATA_W(32), .DEPTH(4), .RESET_PC(0)) dut4 (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_en        (w_load_en),
    .load_addr      (w_load_addr),
    .load_data      (w_load_data),
    .start          (w_start),
    .stall          (1'b0),
    .redirect_valid (1'b0),
    .redirect_pc    (2'd0),
    .inst_out       (w_inst_out),
    .inst_valid     (w_inst_valid),
    .pc_out         (w_pc_out),
    .halted         (w_halted)
`ifdef INST_FETCH_UNIT_PERF_EN
    ,
    .fetch_count    (w_fetch_count)
`endif
  );

  typedef struct {
    logic        ld;
    logic [5:0]  la;
    logic [31:0] ldat;
    logic        st;
    logic        sl;
    logic        rv;
    logic [5:0]  rp;
    logic        ev;
    logic [5:0]  epc;
    logic [31:0] einst;
    logic        eh;
  } vec_t;

  vec_t vecs[22];

  // Behavioural model: state 0 idle, 1 run, 2 halted.
  int          m_state, m_pc, m_pcout;
  bit          m_valid;
  logic [31:0] m_inst;
  logic [31:0] m_mem[Depth];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    load_en = 1'b0; load_addr = '0; load_data = '0; start = 1'b0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
  endtask

  task automatic model_edge();
    if (m_state != 1) begin
      if (load_en) m_mem[load_addr] = load_data;
      if (start) begin
        m_state = 1;
        m_pc    = 0;
        m_valid = 0;
      end
    end else if (redirect_valid) begin
      m_pc    = int'(redirect_pc);
      m_valid = 0;
    end else if (!stall) begin
      if (m_valid && m_inst[31:26] == 6'h3F) begin
        m_state = 2;
        m_valid = 0;
      end else begin
        m_inst  = m_mem[m_pc];
        m_pcout = m_pc;
        m_pc    = (m_pc + 1) % Depth;
        m_valid = 1;
      end
    end
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [31:0] d;
    rst_n = 1'b0;
    clear_inputs();
    w_load_en = 1'b0; w_load_addr = '0; w_load_data = '0; w_start = 1'b0;
    #3;
    check("reset_inst_out", inst_out, 32'd0);
    check("reset_inst_valid", 32'(inst_valid), 32'd0);
    check("reset_pc_out", 32'(pc_out), 32'd0);
    check("reset_halted", 32'(halted), 32'd0);
    #9 rst_n = 1'b1;
    tick();

    // ld la ldat st sl rv rp | ev epc einst eh
    vecs[0]  = '{1'b1, 6'd0, InstAdd,  1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 32'd0,    1'b0};
    vecs[1]  = '{1'b1, 6'd1, InstSub,  1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 32'd0,    1'b0};
    vecs[2]  = '{1'b1, 6'd2, InstHalt, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 32'd0,    1'b0};
    vecs[3]  = '{1'b1, 6'd5, Inst5,    1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 32'd0,    1'b0};
    vecs[4]  = '{1'b0, 6'd0, 32'd0,    1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 32'd0,    1'b0};
    vecs[5]  = '{1'b0, 6'd0, 32'd0,    1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 6'd0, InstAdd,  1'b0};
    vecs[6]  = '{1'b0, 6'd0, 32'd0,    1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 6'd1, InstSub,  1'b0};
    vecs[7]  = '{1'b0, 6'd0, 32'd0,    1'b0, 1'b1, 1'b0, 6'd0, 1'b1, 6'd1, InstSub,  1'b0};
    vecs[8]  = '{1'b0, 6'd0, 32'd0,    1'b0, 1'b1, 1'b0, 6'd0, 1'b1, 6'd1, InstSub,  1'b0};
    vecs[9]  = '{1'b0, 6'd0, 32'd0,    1'b0, 1'b1, 1'b0, 6'd0, 1'b1, 6'd1, InstSub,  1'b0};
    vecs[10] = '{1'b0, 6'd0, 32'd0,    1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 6'd2, InstHalt, 1'b0};
    vecs[11] = '{1'b0, 6'd0, 32'd0,    1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd2, InstHalt, 1'b1};
    vecs[12] = '{1'b0, 6'd0, 32'd0,    1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd2, InstHalt, 1'b1};
    vecs[13] = '{1'b0, 6'd0, 32'd0,    1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd2, InstHalt, 1'b0};
    vecs[14] = '{1'b0, 6'd0, 32'd0,    1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 6'd0, InstAdd,  1'b0};
    vecs[15] = '{1'b0, 6'd0, 32'd0,    1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 6'd1, InstSub,  1'b0};
    vecs[16] = '{1'b0, 6'd0, 32'd0,    1'b0, 1'b1, 1'b1, 6'd5, 1'b0, 6'd1, InstSub,  1'b0};
    vecs[17] = '{1'b0, 6'd0, 32'd0,    1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 6'd5, Inst5,    1'b0};
    vecs[18] = '{1'b0, 6'd0, 32'd0,    1'b0, 1'b0, 1'b1, 6'd2, 1'b0, 6'd5, Inst5,    1'b0};
    vecs[19] = '{1'b0, 6'd0, 32'd0,    1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 6'd2, InstHalt, 1'b0};
    vecs[20] = '{1'b0, 6'd0, 32'd0,    1'b0, 1'b1, 1'b0, 6'd0, 1'b1, 6'd2, InstHalt, 1'b0};
    vecs[21] = '{1'b0, 6'd0, 32'd0,    1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd2, InstHalt, 1'b1};

    for (int i = 0; i < 22; i++) begin
      load_en = vecs[i].ld; load_addr = vecs[i].la; load_data = vecs[i].ldat;
      start = vecs[i].st; stall = vecs[i].sl;
      redirect_valid = vecs[i].rv; redirect_pc = vecs[i].rp;
      tick();
      check($sformatf("vec%0d_valid", i), 32'(inst_valid), 32'(vecs[i].ev));
      check($sformatf("vec%0d_pc", i), 32'(pc_out), 32'(vecs[i].epc));
      check($sformatf("vec%0d_inst", i), inst_out, vecs[i].einst);
      check($sformatf("vec%0d_halted", i), 32'(halted), 32'(vecs[i].eh));
`ifdef INST_FETCH_UNIT_PERF_EN
      if (i == 11) check("perf_count_at_halt", fetch_count, 32'd3);
`endif
    end
    clear_inputs();

    // DEPTH=4 instance: pc_out wraps 3 -> 0.
    for (int a = 0; a < 4; a++) begin
      w_load_en = 1'b1; w_load_addr = 2'(a); w_load_data = 32'h1000_0000 + 32'(a);
      tick();
    end
    w_load_en = 1'b0; w_start = 1'b1;
    tick();
    w_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("wrap%0d_valid", k), 32'(w_inst_valid), 32'd1);
      check($sformatf("wrap%0d_pc", k), 32'(w_pc_out), 32'(k % 4));
      check($sformatf("wrap%0d_inst", k), w_inst_out, 32'h1000_0000 + 32'(k % 4));
    end

    // load/start during RUN are ignored; async reset mid-run clears outputs.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("run_first_pc", 32'(pc_out), 32'd0);
    load_en = 1'b1; load_addr = 6'd0; load_data = 32'hDEAD_BEEF; start = 1'b1;
    tick();
    clear_inputs();
    check("run_ignore_start_pc", 32'(pc_out), 32'd1);
    check("run_ignore_start_inst", inst_out, InstSub);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_inst_out", inst_out, 32'd0);
    check("midreset_valid", 32'(inst_valid), 32'd0);
    check("midreset_pc_out", 32'(pc_out), 32'd0);
    check("midreset_halted", 32'(halted), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    tick();
    check("after_reset_idle_valid", 32'(inst_valid), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("restart_valid", 32'(inst_valid), 32'd1);
    check("restart_pc", 32'(pc_out), 32'd0);
    check("restart_mem_kept", inst_out, InstAdd);

    // Randomized traffic against the model.
    pulse_reset();
    m_state = 0; m_pc = 0; m_pcout = 0; m_valid = 0; m_inst = '0;
    for (int a = 0; a < Depth; a++) begin
      d = $urandom;
      if ($urandom_range(0, 7) == 0) d[31:26] = 6'h3F;
      load_en = 1'b1; load_addr = 6'(a); load_data = d;
      model_edge();
      tick();
    end
    clear_inputs();
    for (int n = 0; n < 800; n++) begin
      d = $urandom;
      if ($urandom_range(0, 7) == 0) d[31:26] = 6'h3F;
      load_en = ($urandom_range(0, 3) == 0);
      load_addr = 6'($urandom_range(0, Depth - 1));
      load_data = d;
      start = (m_state != 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc = 6'($urandom_range(0, Depth - 1));
      model_edge();
      tick();
      check("rand_valid", 32'(inst_valid), 32'(m_valid));
      check("rand_halted", 32'(halted), 32'(m_state == 2));
      check("rand_pc_out", 32'(pc_out), 32'(m_pcout));
      if (m_valid) check("rand_inst", inst_out, m_inst);
    end
    clear_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
